// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: op codes (also used by the
// ALU control decoder), FSM state encoding and the shift-amount width helper.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_NOR = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SLL = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_MUL   = 2'd2
   } alu_state_e;

   // Number of operandB bits that form a shift amount for a given width.
   function automatic int shamt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath for shifts and shift-add multiply. A load captures the
// operands and iteration count; each step advances one bit. The post-step
// values are exposed so the caller can register the final value on the
// step flagged by last_o.
module alu_iter_unit #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               mul_i,
   input  logic               left_i,
   input  logic [WIDTH-1:0]   opa_i,
   input  logic [WIDTH-1:0]   opb_i,
   input  logic [CNT_W-1:0]   count_i,
   output logic [WIDTH-1:0]   shreg_nxt_o,
   output logic [2*WIDTH-1:0] acc_nxt_o,
   output logic               last_o
);

   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mul_q, mul_d;
   logic               left_q, left_d;
   logic [WIDTH-1:0]   shreg_step_s;
   logic [2*WIDTH-1:0] acc_step_s;

   // One-bit step: shift source moves left/right; in multiply mode the
   // shift register holds the multiplier and its LSB gates the add.
   always_comb begin
      shreg_step_s = {1'b0, shreg_q[WIDTH-1:1]};
      acc_step_s   = acc_q;
      if (left_q && !mul_q) begin
         shreg_step_s = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
         shreg_step_s = {1'b0, shreg_q[WIDTH-1:1]};
      end
      if (mul_q && shreg_q[0]) begin
         acc_step_s = acc_q + mcand_q;
      end else begin
         acc_step_s = acc_q;
      end
   end

   assign shreg_nxt_o = shreg_step_s;
   assign acc_nxt_o   = acc_step_s;
   assign last_o      = (cnt_q == CNT_W'(1));

   // Next-state selection: load has priority over step; otherwise hold.
   always_comb begin
      shreg_d = shreg_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mul_d   = mul_q;
      left_d  = left_q;
      if (load_i) begin
         shreg_d = mul_i ? opb_i : opa_i;
         mcand_d = {{WIDTH{1'b0}}, opa_i};
         acc_d   = {(2*WIDTH){1'b0}};
         cnt_d   = count_i;
         mul_d   = mul_i;
         left_d  = left_i;
      end else if (step_i) begin
         shreg_d = shreg_step_s;
         mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
         acc_d   = acc_step_s;
         cnt_d   = cnt_q - CNT_W'(1);
      end else begin
         cnt_d   = cnt_q;
      end
   end

   // Datapath registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= {WIDTH{1'b0}};
         mcand_q <= {(2*WIDTH){1'b0}};
         acc_q   <= {(2*WIDTH){1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         mul_q   <= 1'b0;
         left_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mul_q   <= mul_d;
         left_q  <= left_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU. Logic and add/sub finish in one cycle;
// shifts and multiply iterate in alu_iter_unit while busy is high. Result
// and flags are registered and only change on the edge that raises done.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       aluControl,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int SHAMT_W = shamt_w(WIDTH);
   localparam int CNT_W   = SHAMT_W + 1;

   alu_state_e         state_q, state_d;
   logic [WIDTH-1:0]   result_q, res_d;
   logic               zero_q;
   logic               overflow_q, ovf_d;
   logic               busy_q;
   logic               done_q, done_d;
   logic               upd_s;
   logic               accept_s;
   logic               load_s, step_s, load_mul_s, load_left_s;
   logic [CNT_W-1:0]   count_s;
   logic [WIDTH-1:0]   sum_s, diff_s;
   logic [SHAMT_W-1:0] shamt_s;
   logic [WIDTH-1:0]   shreg_nxt_s;
   logic [2*WIDTH-1:0] acc_nxt_s;
   logic               last_s;

   assign accept_s = start & ~busy_q;
   assign sum_s    = operandA + operandB;
   assign diff_s   = operandA - operandB;
   assign shamt_s  = operandB[SHAMT_W-1:0];
   assign count_s  = load_mul_s ? CNT_W'(WIDTH) : {1'b0, shamt_s};

   alu_iter_unit #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load_s),
      .step_i      (step_s),
      .mul_i       (load_mul_s),
      .left_i      (load_left_s),
      .opa_i       (operandA),
      .opb_i       (operandB),
      .count_i     (count_s),
      .shreg_nxt_o (shreg_nxt_s),
      .acc_nxt_o   (acc_nxt_s),
      .last_o      (last_s)
   );

   // FSM next state, single-cycle op evaluation and result-update strobe.
   always_comb begin
      state_d     = state_q;
      load_s      = 1'b0;
      step_s      = 1'b0;
      load_mul_s  = 1'b0;
      load_left_s = 1'b0;
      upd_s       = 1'b0;
      done_d      = 1'b0;
      res_d       = result_q;
      ovf_d       = overflow_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               case (aluControl)
                  ALU_ADD: begin
                     upd_s  = 1'b1;
                     done_d = 1'b1;
                     res_d  = sum_s;
                     ovf_d  = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                              (sum_s[WIDTH-1] != operandA[WIDTH-1]);
                  end
                  ALU_SUB: begin
                     upd_s  = 1'b1;
                     done_d = 1'b1;
                     res_d  = diff_s;
                     ovf_d  = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                              (diff_s[WIDTH-1] != operandA[WIDTH-1]);
                  end
                  ALU_AND: begin
                     upd_s  = 1'b1;
                     done_d = 1'b1;
                     res_d  = operandA & operandB;
                     ovf_d  = 1'b0;
                  end
                  ALU_OR: begin
                     upd_s  = 1'b1;
                     done_d = 1'b1;
                     res_d  = operandA | operandB;
                     ovf_d  = 1'b0;
                  end
                  ALU_XOR: begin
                     upd_s  = 1'b1;
                     done_d = 1'b1;
                     res_d  = operandA ^ operandB;
                     ovf_d  = 1'b0;
                  end
                  ALU_NOR: begin
                     upd_s  = 1'b1;
                     done_d = 1'b1;
                     res_d  = ~(operandA | operandB);
                     ovf_d  = 1'b0;
                  end
                  ALU_SRL, ALU_SLL: begin
                     if (shamt_s != {SHAMT_W{1'b0}}) begin
                        load_s      = 1'b1;
                        load_left_s = (aluControl == ALU_SLL);
                        state_d     = ST_SHIFT;
                     end else begin
                        // Zero shift amount passes operandA through in one cycle.
                        upd_s  = 1'b1;
                        done_d = 1'b1;
                        res_d  = operandA;
                        ovf_d  = 1'b0;
                     end
                  end
                  ALU_MUL: begin
                     load_s     = 1'b1;
                     load_mul_s = 1'b1;
                     state_d    = ST_MUL;
                  end
                  default: begin
                     // Illegal codes complete immediately with a cleared result.
                     upd_s  = 1'b1;
                     done_d = 1'b1;
                     res_d  = {WIDTH{1'b0}};
                     ovf_d  = 1'b0;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            step_s = 1'b1;
            if (last_s) begin
               state_d = ST_IDLE;
               upd_s   = 1'b1;
               done_d  = 1'b1;
               res_d   = shreg_nxt_s;
               ovf_d   = 1'b0;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_MUL: begin
            step_s = 1'b1;
            if (last_s) begin
               state_d = ST_IDLE;
               upd_s   = 1'b1;
               done_d  = 1'b1;
               res_d   = acc_nxt_s[WIDTH-1:0];
               ovf_d   = |acc_nxt_s[2*WIDTH-1:WIDTH];
            end else begin
               state_d = ST_MUL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, handshake and output registers; result/flags load only with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= {WIDTH{1'b0}};
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= done_d;
         if (upd_s) begin
            result_q   <= res_d;
            zero_q     <= (res_d == {WIDTH{1'b0}});
            overflow_q <= ovf_d;
         end else begin
            result_q   <= result_q;
         end
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = overflow_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver pushes expected results computed
// from plain arithmetic; a monitor pops and compares on every done pulse.
module tb_seq_alu;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [3:0]   aluControl;
   logic [W-1:0] operandA, operandB;
   logic [W-1:0] result;
   logic         zero, overflow, busy, done;

   typedef struct {
      logic [W-1:0] res;
      logic         ovf;
      logic         zro;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   seq_alu #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .aluControl (aluControl),
      .operandA   (operandA),
      .operandB   (operandB),
      .result     (result),
      .zero       (zero),
      .overflow   (overflow),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: plain integer arithmetic on the op-code table.
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] res, output logic ovf, output int extra);
      int     sa, sbv, s, k;
      longint p;
      sa    = int'($signed(a));
      sbv   = int'($signed(b));
      k     = int'(b) % W;
      ovf   = 1'b0;
      extra = 0;
      res   = '0;
      case (op)
         4'd0: begin s = sa + sbv; res = s[W-1:0]; ovf = (s > 32767) || (s < -32768); end
         4'd1: begin s = sa - sbv; res = s[W-1:0]; ovf = (s > 32767) || (s < -32768); end
         4'd2: res = a & b;
         4'd3: res = a | b;
         4'd4: res = a ^ b;
         4'd5: res = ~(a | b);
         4'd6: begin res = a >> k; extra = k; end
         4'd7: begin res = a << k; extra = k; end
         4'd8: begin
            p     = longint'(a) * longint'(b);
            res   = p[W-1:0];
            ovf   = (p >= 65536);
            extra = W;
         end
         default: res = '0;
      endcase
   endfunction

   // Issue one operation once busy is low; while waiting, spray ignored starts.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t         e;
      logic [W-1:0] r;
      logic         o;
      int           x;
      int           guard;
      guard = 0;
      while (busy === 1'b1) begin
         start      = 1'($urandom_range(0, 1));
         aluControl = 4'($urandom);
         operandA   = 16'($urandom);
         operandB   = 16'($urandom);
         @(negedge clk);
         guard++;
         if (guard > 200) begin
            chk("busy_timeout", 32'(busy), 32'd0);
            break;
         end
      end
      start      = 1'b1;
      aluControl = op;
      operandA   = a;
      operandB   = b;
      model(op, a, b, r, o, x);
      e.res = r;
      e.ovf = o;
      e.zro = (r == '0);
      e.cyc = cyc + 1 + x;
      sb.push_back(e);
      @(negedge clk);
      start      = 1'b0;
      aluControl = 4'($urandom);
      operandA   = 16'($urandom);
      operandB   = 16'($urandom);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         exp_t e;
         chk("done_with_busy", 32'(busy), 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("zero", 32'(zero), 32'(e.zro));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      int           guard;

      rst_n      = 1'b0;
      start      = 1'b0;
      aluControl = 4'd0;
      operandA   = '0;
      operandB   = '0;
      repeat (3) @(negedge clk);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases: overflow edge, back-to-back, shifts, multiply, illegal.
      issue(4'd0, 16'h7FFF, 16'h0001);
      issue(4'd1, 16'h0005, 16'h0005);
      issue(4'd2, 16'hF0F0, 16'h0FF0);
      issue(4'd7, 16'h0001, 16'h0004);
      issue(4'd6, 16'h1234, 16'h0000);
      issue(4'd6, 16'h8001, 16'h0013);
      issue(4'd8, 16'd300,  16'd300);
      issue(4'd0, 16'h1111, 16'h2222);
      issue(4'd8, 16'd3,    16'd5);
      issue(4'd12, 16'hFFFF, 16'h0000);
      issue(4'd1, 16'h8000, 16'h0001);
      issue(4'd5, 16'h0000, 16'h0000);
      issue(4'd7, 16'hFFFF, 16'h000F);
      issue(4'd8, 16'hFFFF, 16'hFFFF);

      // Reset in the middle of a multiply: abort, outputs cleared, no done.
      issue(4'd8, 16'd300, 16'd300);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", 32'(result), 32'd0);
      chk("midrst_zero", 32'(zero), 32'd0);
      chk("midrst_overflow", 32'(overflow), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("postrst_busy", 32'(busy), 32'd0);

      // Randomized traffic with bias toward corner operands and iterative ops.
      for (int i = 0; i < 200; i++) begin
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) op = 4'd8;
         if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(6, 7));
         case ($urandom_range(0, 3))
            0: a = 16'h7FFF;
            1: a = 16'h8000;
            default: a = 16'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0: b = 16'hFFFF;
            1: b = 16'h0000;
            2: b = 16'h8000;
            default: b = 16'($urandom);
         endcase
         issue(op, a, b);
      end

      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
